// File: rtl/special_insn_sequencer.sv
// Multi-cycle sequencer for LUI/AUIPC/JAL/JALR: computes result and jump target,
// drives a PC redirect/flush window for jumps, then offers the write-back.
// Optional macro SPECIAL_SEQ_MISALIGN_TRAP_EN adds the trap port.
module special_insn_sequencer #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_data,
    output logic             illegal,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] retired_count
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
    ,
    output logic             trap
`endif
);

    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;

    localparam logic [2:0] CLS_JALR  = 3'b111;
    localparam logic [2:0] CLS_JAL   = 3'b110;
    localparam logic [2:0] CLS_LUI   = 3'b100;
    localparam logic [2:0] CLS_AUIPC = 3'b101;
    localparam logic [2:0] CLS_NONE  = 3'b000;

    // Counter loads N-1 so the REDIR window lasts exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_REDIR, S_WB} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cls_reg, in_cls;
    logic [4:0]        rd_reg;
    logic [XLEN-1:0]   pc_reg, imm_reg, rs1_reg;
    logic [XLEN-1:0]   result_reg, target_reg;
    logic [3:0]        cnt_reg, cnt_next;
    logic              illegal_reg, illegal_next;
    logic [CNT_W-1:0]  count_reg;
    logic              accept, wb_fire, is_jump;
    logic [XLEN-1:0]   sum_pc_imm, sum_rs1_imm, pc_plus4;
    logic [XLEN-1:0]   calc_result, calc_target;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
    logic              trap_reg, trap_next;
`endif

    always_comb begin
        in_cls = CLS_NONE;
        case (opcode)
            OP_LUI:   in_cls = CLS_LUI;
            OP_AUIPC: in_cls = CLS_AUIPC;
            OP_JAL:   in_cls = CLS_JAL;
            OP_JALR:  in_cls = CLS_JALR;
            default:  in_cls = CLS_NONE;
        endcase
    end

    assign sum_pc_imm  = pc_reg + imm_reg;
    assign sum_rs1_imm = rs1_reg + imm_reg;
    assign pc_plus4    = pc_reg + XLEN'(4);
    assign is_jump     = (cls_reg[2:1] == 2'b11);

    always_comb begin
        calc_result = '0;
        calc_target = sum_pc_imm;
        case (cls_reg)
            CLS_LUI:   calc_result = imm_reg;
            CLS_AUIPC: calc_result = sum_pc_imm;
            CLS_JAL:   calc_result = pc_plus4;
            CLS_JALR: begin
                calc_result = pc_plus4;
                calc_target = {sum_rs1_imm[XLEN-1:1], 1'b0};
            end
            default:   calc_result = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        illegal_next = 1'b0;
        accept       = 1'b0;
        wb_fire      = 1'b0;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
        trap_next    = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_cls != CLS_NONE) begin
                        accept     = 1'b1;
                        state_next = S_CALC;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (is_jump) begin
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
                    if (calc_target[1]) begin
                        trap_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_REDIR;
                        cnt_next   = FLUSH_LAST;
                    end
`else
                    state_next = S_REDIR;
                    cnt_next   = FLUSH_LAST;
`endif
                end else begin
                    state_next = S_WB;
                end
            end
            S_REDIR: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_WB;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    wb_fire    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cls_reg     <= CLS_NONE;
            rd_reg      <= '0;
            pc_reg      <= '0;
            imm_reg     <= '0;
            rs1_reg     <= '0;
            result_reg  <= '0;
            target_reg  <= '0;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            count_reg   <= '0;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
            trap_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            illegal_reg <= illegal_next;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
            trap_reg    <= trap_next;
`endif
            if (accept) begin
                cls_reg <= in_cls;
                rd_reg  <= rd;
                pc_reg  <= pc;
                imm_reg <= imm;
                rs1_reg <= rs1_data;
            end
            if (state_reg == S_CALC) begin
                result_reg <= calc_result;
                target_reg <= calc_target;
            end
            if (wb_fire) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    // Data outputs are gated so they read zero outside the state that presents them.
    assign in_ready       = (state_reg == S_IDLE);
    assign redirect_valid = (state_reg == S_REDIR);
    assign flush          = redirect_valid;
    assign redirect_pc    = redirect_valid ? target_reg : '0;
    assign wb_valid       = (state_reg == S_WB);
    assign wb_rd          = wb_valid ? rd_reg : 5'd0;
    assign wb_data        = wb_valid ? result_reg : '0;
    assign illegal        = illegal_reg;
    assign retired_count  = count_reg;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
    assign trap           = trap_reg;
`endif

endmodule

// File: tb/tb_special_insn_sequencer.sv
// Scoreboard bench for special_insn_sequencer: stimulus pushes expected write-backs
// and redirects into queues; a negedge monitor pops and compares them.
module tb_special_insn_sequencer;

    localparam int XLEN = 32;
    localparam int F    = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       opcode = '0;
    logic [4:0]       rd = '0;
    logic [XLEN-1:0]  pc = '0;
    logic [XLEN-1:0]  imm = '0;
    logic [XLEN-1:0]  rs1_data = '0;
    logic             illegal;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             wb_valid;
    logic             wb_ready = 1'b1;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] retired_count;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
    logic             trap;
`endif

    special_insn_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(F), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .pc(pc), .imm(imm), .rs1_data(rs1_data),
        .illegal(illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .retired_count(retired_count)
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
        , .trap(trap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              acc;
        int              lat;
    } wb_t;

    wb_t             sb_q[$];
    logic [XLEN-1:0] rq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   ill_exp = 0, ill_seen = 0;
    int   trap_exp = 0, trap_seen = 0;
    int   exp_ret = 0;
    int   first_wb = -1;
    int   run_len = 0;
    bit   prev_rv = 1'b0, prev_ill = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flag(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=present required=absent", name);
    endfunction

    // Monitor: compares every presented output against the queued expectations.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("retired_count", retired_count, exp_ret[CNT_W-1:0]);
            if (illegal) begin
                ill_seen++;
                chk("illegal_single_cycle", prev_ill, 0);
                chk("illegal_in_idle", in_ready, 1);
            end
            prev_ill = illegal;
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
            if (trap) trap_seen++;
`endif
            chk("flush_eq_redirect", flush, redirect_valid);
            if (redirect_valid) begin
                if (rq.size() == 0) flag("unexpected_redirect");
                else chk("redirect_pc", redirect_pc, rq[0]);
                run_len++;
            end else if (prev_rv) begin
                chk("redirect_cycles", run_len, F);
                if (rq.size() > 0) begin
                    $display("redirect pc=0x%08h cycles=%0d", rq[0], run_len);
                    void'(rq.pop_front());
                end
                run_len = 0;
            end
            prev_rv = redirect_valid;
            if (wb_valid) begin
                chk("in_ready_low_in_wb", in_ready, 0);
                if (sb_q.size() == 0) begin
                    flag("unexpected_wb");
                end else begin
                    if (first_wb < 0) begin
                        first_wb = cyc;
                        chk("wb_latency", cyc - sb_q[0].acc, sb_q[0].lat);
                    end
                    chk("wb_rd", wb_rd, sb_q[0].rd);
                    chk("wb_data", wb_data, sb_q[0].data);
                    if (wb_ready) begin
                        $display("wb rd=%0d data=0x%08h retired=%0d", wb_rd, wb_data, exp_ret + 1);
                        void'(sb_q.pop_front());
                        first_wb = -1;
                        exp_ret++;
                    end
                end
            end
        end else begin
            run_len  = 0;
            prev_rv  = 1'b0;
            prev_ill = 1'b0;
            first_wb = -1;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout in_ready actual=0 required=1");
        end
    endtask

    // kind: 0 = illegal, 1 = plain write-back, 2 = jump, 3 = jump that traps
    task automatic issue(input logic [4:0] op, input logic [4:0] r, input logic [XLEN-1:0] p,
                         input logic [XLEN-1:0] i, input logic [XLEN-1:0] s, input int kind,
                         input logic [XLEN-1:0] res, input logic [XLEN-1:0] tgt);
        wb_t e;
        wait_ready();
        opcode = op; rd = r; pc = p; imm = i; rs1_data = s; in_valid = 1'b1;
        if (kind == 0) begin
            ill_exp++;
        end else if (kind == 3) begin
            trap_exp++;
        end else begin
            e.rd = r; e.data = res; e.acc = cyc; e.lat = (kind == 2) ? 2 + F : 2;
            sb_q.push_back(e);
            if (kind == 2) rq.push_back(tgt);
        end
        $display("issue op=%b rd=%0d pc=0x%08h imm=0x%08h rs1=0x%08h", op, r, p, i, s);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk); #1;
        while ((sb_q.size() != 0 || rq.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending actual=%0d required=0", sb_q.size() + rq.size());
        end
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_redirect_valid"}, redirect_valid, 0);
        chk({tag, "_redirect_pc"}, redirect_pc, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_retired"}, retired_count, 0);
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
        chk({tag, "_trap"}, trap, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog sim_time actual=%0t required=<200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        issue(5'b01101, 5'd5, 32'h0000_0000, 32'h1234_5000, 32'h0, 1, 32'h1234_5000, 32'h0);
        drain();
        issue(5'b00101, 5'd6, 32'hFFFF_F000, 32'h0000_2000, 32'h0, 1, 32'h0000_1000, 32'h0);
        drain();
        issue(5'b11011, 5'd1, 32'h0000_0100, 32'h0000_0040, 32'h0, 2, 32'h0000_0104, 32'h0000_0140);
        drain();
        issue(5'b11001, 5'd2, 32'h0000_0300, 32'h0000_0010, 32'h0000_0201, 2, 32'h0000_0304, 32'h0000_0210);
        drain();
        issue(5'b01101, 5'd0, 32'h0000_0000, 32'h00AB_C000, 32'h0, 1, 32'h00AB_C000, 32'h0);
        drain();
`ifdef SPECIAL_SEQ_MISALIGN_TRAP_EN
        issue(5'b11001, 5'd3, 32'h0000_0500, 32'h0000_0000, 32'h0000_0202, 3, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("trap_pulses", trap_seen, trap_exp);
`endif
        issue(5'b01100, 5'd4, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_pulses", ill_seen, ill_exp);

        // Stall the write-back; an illegal opcode offered meanwhile must be ignored.
        wb_ready = 1'b0;
        issue(5'b01101, 5'd7, 32'h0, 32'h0000_A000, 32'h0, 1, 32'h0000_A000, 32'h0);
        n = 0;
        while (!wb_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_wb_valid_seen", wb_valid, 1);
        opcode = 5'b01100; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_ignored_outside_idle", ill_seen, ill_exp);

        // Abort a jump mid-redirect with a single reset edge.
        mon_en = 1'b0;
        wait_ready();
        opcode = 5'b11011; rd = 5'd9; pc = 32'h400; imm = 32'h20; in_valid = 1'b1;
        $display("issue op=%b rd=%0d pc=0x%08h (to be aborted)", opcode, rd, pc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!redirect_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_redirect_reached", redirect_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        sb_q.delete();
        rq.delete();
        exp_ret = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        issue(5'b01101, 5'd8, 32'h0, 32'h0000_1000, 32'h0, 1, 32'h0000_1000, 32'h0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("final_retired", retired_count, exp_ret[CNT_W-1:0]);
        chk("final_sb_empty", sb_q.size(), 0);
        chk("final_rq_empty", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
